fp8_matmul_seq: RTL and testbench

//  Sequential NxN matrix multiplier, C = A x B, on small sign|exponent|mantissa floats.
//  - Generalises the fixed 3x3 combinational multiplier to any dimension N and float format.
//  - Matrices are loaded element-by-element and computed with one registered MAC (1 term/clk).
//  - Results stream out row-major over a valid/ready handshake.

---
 rtl/fp8_matmul_seq_if.sv | 31 +++
 rtl/fp8_matmul_seq.sv | 183 ++++++++++++++++++
 tb/tb_fp8_matmul_seq.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp8_matmul_seq_if.sv
// Load, control and result-stream signals for the sequential small-float matrix multiplier.
// Result handshake: a transfer happens on a rising clk edge where out_valid & out_ready are both high;
// while out_valid is high and out_ready is low, out_data/out_addr/out_last hold their values.
interface fp8_matmul_seq_if #(
   parameter int W  = 8,
   parameter int AW = 4
);
   logic          wr_en;
   logic          wr_sel;
   logic [AW-1:0] wr_addr;
   logic [W-1:0]  wr_data;
   logic          start;
   logic          busy;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [AW-1:0] out_addr;
   logic          out_last;
   logic          done;
   logic          ovf;

   modport master (
      output wr_en, wr_sel, wr_addr, wr_data, start, out_ready,
      input  busy, out_valid, out_data, out_addr, out_last, done, ovf
   );

   modport slave (
      input  wr_en, wr_sel, wr_addr, wr_data, start, out_ready,
      output busy, out_valid, out_data, out_addr, out_last, done, ovf
   );
endinterface

// File: rtl/fp8_matmul_seq.sv
// Sequential NxN matrix multiplier C = A x B on sign|exponent|mantissa floats,
// one registered multiply-accumulate per clock, results streamed row-major.
module fp8_matmul_seq #(
   parameter int N     = 3,
   parameter int EXP_W = 3,
   parameter int MAN_W = 4,
   parameter int BIAS  = 3
) (
   input logic              clk,
   input logic              rst,
   fp8_matmul_seq_if.slave  bus
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int NN   = N * N;
   localparam int AW   = $clog2(NN);
   localparam int IW   = $clog2(N);
   localparam int SW   = MAN_W + 1;
   localparam int EMAX = (1 << EXP_W) - 1;

   typedef enum logic [1:0] {IDLE, COMPUTE, OUT} state_t;

   typedef struct packed {
      logic [W-1:0] val;
      logic         ovf;
   } fres_t;

   // Range-check a biased exponent: saturate high (flagged), flush low to +0.
   function automatic fres_t pack_f(input logic s, input int ex, input logic [MAN_W-1:0] man);
      pack_f = '0;
      if (ex > EMAX) begin
         pack_f.val = {s, {(W-1){1'b1}}};
         pack_f.ovf = 1'b1;
      end else if (ex >= 1) begin
         pack_f.val = {s, ex[EXP_W-1:0], man};
      end
   endfunction

   function automatic fres_t mul_f(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*SW-1:0] p;
      int              ex;
      mul_f = '0;
      p  = (2*SW)'({1'b1, a[MAN_W-1:0]}) * (2*SW)'({1'b1, b[MAN_W-1:0]});
      ex = int'(a[W-2:MAN_W]) + int'(b[W-2:MAN_W]) - BIAS;
      if (a[W-2:MAN_W] == '0 || b[W-2:MAN_W] == '0)
         mul_f = '0;
      else if (p[2*SW-1])
         mul_f = pack_f(a[W-1] ^ b[W-1], ex + 1, p[2*SW-2 -: MAN_W]);
      else
         mul_f = pack_f(a[W-1] ^ b[W-1], ex, p[2*SW-3 -: MAN_W]);
   endfunction

   function automatic fres_t add_f(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0]  lg, sm;
      logic [SW-1:0] sig_l, sig_s, dif;
      logic [SW:0]   sum;
      int            ex, pos;
      add_f = '0;
      lg = a;
      sm = b;
      if (a[W-2:MAN_W] == '0) begin
         add_f.val = b;
      end else if (b[W-2:MAN_W] == '0) begin
         add_f.val = a;
      end else begin
         // Exponent-then-mantissa compare orders magnitudes; the smaller one loses its shifted-out bits.
         if (a[W-2:0] < b[W-2:0]) begin
            lg = b;
            sm = a;
         end
         sig_l = {1'b1, lg[MAN_W-1:0]};
         sig_s = {1'b1, sm[MAN_W-1:0]} >> (lg[W-2:MAN_W] - sm[W-2:MAN_W]);
         ex    = int'(lg[W-2:MAN_W]);
         if (lg[W-1] == sm[W-1]) begin
            sum = {1'b0, sig_l} + {1'b0, sig_s};
            if (sum[SW])
               add_f = pack_f(lg[W-1], ex + 1, sum[MAN_W:1]);
            else
               add_f = pack_f(lg[W-1], ex, sum[MAN_W-1:0]);
         end else begin
            dif = sig_l - sig_s;
            pos = 0;
            for (int n = 0; n < SW; n++)
               if (dif[n]) pos = n;
            if (dif != '0)
               add_f = pack_f(lg[W-1], ex - (SW - 1 - pos), MAN_W'(dif << (SW - 1 - pos)));
         end
      end
   endfunction

   state_t         state, state_nx;
   logic [W-1:0]   mem_a [NN];
   logic [W-1:0]   mem_b [NN];
   logic [W-1:0]   acc;
   logic [IW-1:0]  i, j, k;
   logic           ovf, done;
   logic [AW-1:0]  a_idx, b_idx;
   logic           last_elem;
   fres_t          term, sum;

   assign a_idx     = AW'(int'(i) * N + int'(k));
   assign b_idx     = AW'(int'(k) * N + int'(j));
   assign term      = mul_f(mem_a[a_idx], mem_b[b_idx]);
   assign sum       = add_f(acc, term.val);
   assign last_elem = (i == IW'(N-1)) && (j == IW'(N-1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = COMPUTE;
         COMPUTE: if (k == IW'(N-1)) state_nx = OUT;
         OUT:     if (bus.out_ready) state_nx = last_elem ? IDLE : COMPUTE;
         default: state_nx = IDLE;
      endcase
   end

   // Storage only accepts writes in IDLE, so a write issued with start is visible to the first term.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < NN; n++) begin
            mem_a[n] <= '0;
            mem_b[n] <= '0;
         end
      end else if (state == IDLE && bus.wr_en && int'(bus.wr_addr) < NN) begin
         if (bus.wr_sel) mem_b[bus.wr_addr] <= bus.wr_data;
         else            mem_a[bus.wr_addr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc  <= '0;
         i    <= '0;
         j    <= '0;
         k    <= '0;
         ovf  <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               acc <= '0;
               i   <= '0;
               j   <= '0;
               k   <= '0;
               ovf <= 1'b0;
            end
            COMPUTE: begin
               acc <= sum.val;
               ovf <= ovf | term.ovf | sum.ovf;
               k   <= (k == IW'(N-1)) ? '0 : k + 1'b1;
            end
            OUT: if (bus.out_ready) begin
               acc <= '0;
               k   <= '0;
               if (last_elem) begin
                  i    <= '0;
                  j    <= '0;
                  done <= 1'b1;
               end else if (j == IW'(N-1)) begin
                  j <= '0;
                  i <= i + 1'b1;
               end else begin
                  j <= j + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = (state == OUT);
   assign bus.out_data  = acc;
   assign bus.out_addr  = AW'(int'(i) * N + int'(j));
   assign bus.out_last  = (state == OUT) && last_elem;
   assign bus.done      = done;
   assign bus.ovf       = ovf;
endmodule

// File: tb/tb_fp8_matmul_seq.sv
// Bench for fp8_matmul_seq: directed and random runs against a value-level float model,
// with a queue-based scoreboard checked by an independent output monitor.
module tb_fp8_matmul_seq;
   localparam int N     = 3;
   localparam int EXP_W = 3;
   localparam int MAN_W = 4;
   localparam int BIAS  = 3;
   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int NN    = N * N;
   localparam int AW    = $clog2(NN);
   localparam int EMAX  = (1 << EXP_W) - 1;
   localparam int EW    = 1 + AW + W;

   typedef struct packed {
      logic [W-1:0] val;
      logic         ovf;
   } fr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fp8_matmul_seq_if #(.W(W), .AW(AW)) bus();

   fp8_matmul_seq #(.N(N), .EXP_W(EXP_W), .MAN_W(MAN_W), .BIAS(BIAS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int           errors = 0;
   int           checks = 0;
   logic [EW-1:0] exp_q[$];
   logic [W-1:0] ma [NN];
   logic [W-1:0] mb [NN];
   logic [W-1:0] exp_c [NN];
   bit           exp_ovf;
   logic [EW-1:0] item;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: values are sig * 2^scale; alignment drops bits below the larger exponent.
   function automatic fr_t ref_encode(input bit s, input longint mag, input int scale);
      fr_t    r;
      int     p, e;
      longint m;
      r = '0;
      if (mag == 0) return r;
      p = 0;
      for (int n = 0; n < 40; n++) if (mag[n]) p = n;
      e = p + scale + BIAS;
      m = (p >= MAN_W) ? (mag >> (p - MAN_W)) : (mag << (MAN_W - p));
      if (e > EMAX) begin
         r.val = {s, {(W-1){1'b1}}};
         r.ovf = 1'b1;
      end else if (e >= 1) begin
         r.val = {s, e[EXP_W-1:0], m[MAN_W-1:0]};
      end
      return r;
   endfunction

   function automatic longint ref_sig(input logic [W-1:0] v);
      return longint'((1 << MAN_W) + int'(v[MAN_W-1:0]));
   endfunction

   function automatic fr_t ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      fr_t r;
      int  ea, eb;
      r  = '0;
      ea = int'(a[W-2:MAN_W]);
      eb = int'(b[W-2:MAN_W]);
      if (ea == 0 || eb == 0) return r;
      return ref_encode(a[W-1] ^ b[W-1], ref_sig(a) * ref_sig(b), ea + eb - 2*BIAS - 2*MAN_W);
   endfunction

   function automatic fr_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
      fr_t    r;
      int     ea, eb, em;
      longint ta, tb, tot;
      r  = '0;
      ea = int'(a[W-2:MAN_W]);
      eb = int'(b[W-2:MAN_W]);
      if (ea == 0) begin r.val = b; return r; end
      if (eb == 0) begin r.val = a; return r; end
      em  = (ea > eb) ? ea : eb;
      ta  = ref_sig(a) >> (em - ea);
      tb  = ref_sig(b) >> (em - eb);
      if (a[W-1]) ta = -ta;
      if (b[W-1]) tb = -tb;
      tot = ta + tb;
      if (tot == 0) return r;
      return ref_encode(tot < 0, (tot < 0) ? -tot : tot, em - BIAS - MAN_W);
   endfunction

   task automatic ref_run();
      fr_t          t, s;
      logic [W-1:0] acc;
      exp_ovf = 1'b0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            acc = '0;
            for (int x = 0; x < N; x++) begin
               t = ref_mul(ma[r*N+x], mb[x*N+c]);
               s = ref_add(acc, t.val);
               exp_ovf = exp_ovf | t.ovf | s.ovf;
               acc = s.val;
            end
            exp_c[r*N+c] = acc;
         end
   endtask

   function automatic logic [W-1:0] rand_elem();
      logic [W-1:0] v;
      if ($urandom_range(0, 4) == 0) return '0;
      v[W-1]       = 1'($urandom_range(0, 1));
      v[W-2:MAN_W] = EXP_W'($urandom_range(1, 5));
      v[MAN_W-1:0] = MAN_W'($urandom());
      return v;
   endfunction

   task automatic rand_mats();
      for (int n = 0; n < NN; n++) begin
         ma[n] = rand_elem();
         mb[n] = rand_elem();
      end
      ref_run();
   endtask

   task automatic clear_mats();
      for (int n = 0; n < NN; n++) begin
         ma[n]    = '0;
         mb[n]    = '0;
         exp_c[n] = '0;
      end
      exp_ovf = 1'b0;
   endtask

   task automatic push_expected();
      for (int n = 0; n < NN; n++)
         exp_q.push_back({(n == NN-1), AW'(n), exp_c[n]});
   endtask

   task automatic write_elem(input bit sel, input int addr, input logic [W-1:0] data);
      bus.wr_en   = 1'b1;
      bus.wr_sel  = sel;
      bus.wr_addr = AW'(addr);
      bus.wr_data = data;
      @(posedge clk); #1;
      bus.wr_en   = 1'b0;
   endtask

   // B[0] is written in the same cycle as start, so the first term depends on write-before-compute.
   task automatic load_start();
      for (int n = NN; n < (1 << AW); n++) begin
         write_elem(1'b0, n, 8'hFF);
         write_elem(1'b1, n, 8'hFF);
      end
      for (int n = 0; n < NN; n++) write_elem(1'b0, n, ma[n]);
      for (int n = NN-1; n >= 1; n--) write_elem(1'b1, n, mb[n]);
      push_expected();
      bus.wr_en   = 1'b1;
      bus.wr_sel  = 1'b1;
      bus.wr_addr = '0;
      bus.wr_data = mb[0];
      bus.start   = 1'b1;
      @(posedge clk); #1;
      bus.wr_en   = 1'b0;
      bus.start   = 1'b0;
   endtask

   task automatic pulse_start();
      push_expected();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic run_wait(input int bp_addr, input bit rnd_ready, input bit misuse,
                           output int t_valid, output int t_done);
      int            cnt;
      bit            bp_used;
      logic [W-1:0]  hold_d;
      logic [AW-1:0] hold_a;
      cnt = 0; t_valid = -1; t_done = -1; bp_used = 0;
      while (cnt < 1000 && t_done < 0) begin
         @(posedge clk); #1;
         cnt++;
         bus.wr_en = 1'b0;
         bus.start = 1'b0;
         if (bus.out_valid && t_valid < 0) t_valid = cnt;
         if (bus.done) begin
            t_done = cnt;
         end else if (bp_addr >= 0 && !bp_used && bus.out_valid && int'(bus.out_addr) == bp_addr) begin
            bus.out_ready = 1'b0;
            hold_d  = bus.out_data;
            hold_a  = bus.out_addr;
            bp_used = 1;
            repeat (5) begin
               @(posedge clk); #1;
               cnt++;
               check("bp_valid", bus.out_valid, 1);
               check("bp_data_stable", bus.out_data, hold_d);
               check("bp_addr_stable", bus.out_addr, hold_a);
            end
            bus.out_ready = 1'b1;
         end else begin
            if (rnd_ready) bus.out_ready = ($urandom_range(0, 2) != 0);
            if (misuse && bus.busy) begin
               bus.wr_en   = 1'b1;
               bus.wr_sel  = 1'($urandom_range(0, 1));
               bus.wr_addr = AW'($urandom_range(0, NN-1));
               bus.wr_data = W'($urandom());
               bus.start   = 1'b1;
            end
         end
      end
      bus.out_ready = 1'b1;
      bus.wr_en     = 1'b0;
      bus.start     = 1'b0;
      if (t_done < 0) begin
         checks++;
         errors++;
         $display("FAIL run_timeout: no done pulse within %0d cycles", cnt);
      end else begin
         check("ovf_at_done", bus.ovf, exp_ovf);
         check("all_results_seen", exp_q.size(), 0);
         @(posedge clk); #1;
         check("done_one_cycle", bus.done, 0);
         check("idle_after_done", bus.busy, 0);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: addr 0x%0h data 0x%0h with nothing expected", bus.out_addr, bus.out_data);
         end else begin
            item = exp_q.pop_front();
            check("out_data", bus.out_data, item[W-1:0]);
            check("out_addr", bus.out_addr, item[W+AW-1:W]);
            check("out_last", bus.out_last, item[EW-1]);
         end
      end
   end

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_out_valid"}, bus.out_valid, 0);
      check({tag, "_out_data"}, bus.out_data, 0);
      check({tag, "_out_addr"}, bus.out_addr, 0);
      check({tag, "_out_last"}, bus.out_last, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_ovf"}, bus.ovf, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int tv, td;
      bus.wr_en     = 1'b0;
      bus.wr_sel    = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.start     = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Identity times B returns B; also pins latency and run length.
      clear_mats();
      ma[0] = 8'h30; ma[4] = 8'h30; ma[8] = 8'h30;
      mb = '{8'h10, 8'h90, 8'h20, 8'hA0, 8'h30, 8'h38, 8'hB8, 8'h21, 8'h12};
      exp_c = mb;
      load_start();
      run_wait(-1, 0, 0, tv, td);
      check("first_valid_edges", tv, 3);
      check("start_to_done_edges", td, 36);

      // Product truncation: 1.0625^2 = 1.12890625 -> 1.125.
      clear_mats();
      ma[0] = 8'h31; mb[0] = 8'h31; exp_c[0] = 8'h32;
      load_start();
      run_wait(-1, 1, 0, tv, td);

      // Exact cancellation then underflowing product.
      clear_mats();
      ma[0] = 8'h30; ma[1] = 8'hB0; ma[2] = 8'h10;
      mb[0] = 8'h30; mb[3] = 8'h30; mb[6] = 8'h10;
      load_start();
      run_wait(-1, 1, 0, tv, td);

      // 16 x -16 saturates to the most negative value.
      clear_mats();
      ma[0] = 8'h70; mb[0] = 8'hF0; exp_c[0] = 8'hFF; exp_ovf = 1'b1;
      load_start();
      run_wait(-1, 0, 0, tv, td);

      clear_mats();
      ma[0] = 8'h31; mb[0] = 8'h31; exp_c[0] = 8'h32;
      load_start();
      run_wait(-1, 0, 0, tv, td);

      rand_mats();
      load_start();
      run_wait(4, 0, 0, tv, td);

      rand_mats();
      load_start();
      run_wait(-1, 0, 1, tv, td);

      // Reset during COMPUTE, then a run on the cleared storage.
      rand_mats();
      load_start();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_outputs_zero("midrun_reset");
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      clear_mats();
      pulse_start();
      run_wait(-1, 0, 0, tv, td);

      for (int r = 0; r < 4; r++) begin
         rand_mats();
         load_start();
         run_wait(-1, 1, 0, tv, td);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
